blender_mode_sequencer: RTL

//  User-command front end for the 30-speed blender FSM: turns button presses into the 5-bit Mode code the blender

---
 rtl/blender_pkg.sv | 13 +
 rtl/blender_tick_timer.sv | 17 +
 rtl/blender_mode_sequencer.sv | 116 +++++++++++
 3 files changed

// File: rtl/blender_pkg.sv
// blender_pkg: shared state encoding, mode codes and program speed table for the blender sequencer
package blender_pkg;
  typedef enum logic [1:0] {IDLE, MANUAL, PROGRAM, PULSE} seq_state_t;
  localparam logic [4:0] MODE_OFF      = 5'd0;
  localparam logic [4:0] MODE_PULSE33  = 5'd29;
  localparam logic [4:0] MODE_PULSE66  = 5'd30;
  localparam logic [4:0] MODE_PULSE100 = 5'd31;
  localparam logic [4:0] PROG_SPEED [4] = '{5'd6, 5'd12, 5'd18, 5'd23};
  // last step always runs at the configured top speed; earlier steps clamp to it
  function automatic logic [4:0] prog_speed(input logic [1:0] s, input logic [4:0] max_speed);
    return (s == 2'd3 || PROG_SPEED[s] > max_speed) ? max_speed : PROG_SPEED[s];
  endfunction
endpackage

// File: rtl/blender_tick_timer.sv
// blender_tick_timer: saturating cycle counter flagging the last cycle before a selectable terminal count
module blender_tick_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] terminal,
  output logic         done
);
  logic [W-1:0] count;
  always_ff @(posedge clk)
    if (reset || clear) count <= '0;
    else if (enable && count != '1) count <= count + 1'b1;
  assign done = count == terminal - 1'b1;
endmodule

// File: rtl/blender_mode_sequencer.sv
// blender_mode_sequencer: panel buttons to blender Mode code (manual, auto-ramp program, pulse, idle auto-off)
// Optional lid interlock when BLENDER_SEQ_LID_INTERLOCK_EN is defined.
module blender_mode_sequencer
  import blender_pkg::*;
#(
  parameter int STEP_TICKS   = 1000,
  parameter int IDLE_TIMEOUT = 60000,
  parameter int MAX_SPEED    = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_stop,
  input  logic       btn_prog,
  input  logic [1:0] pulse_sel,
`ifdef BLENDER_SEQ_LID_INTERLOCK_EN
  input  logic       lid_closed,
  output logic       lid_fault,
`endif
  output logic [4:0] mode,
  output logic       prog_active,
  output logic       prog_done,
  output logic [1:0] step_idx
);
  localparam int TW = $clog2((STEP_TICKS > IDLE_TIMEOUT ? STEP_TICKS : IDLE_TIMEOUT) + 1);
  localparam logic [4:0] MAXS = 5'(MAX_SPEED);
  seq_state_t state, ns;
  logic [4:0] speed, nspeed, nmode, cur;
  logic [1:0] step, nstep;
  logic [3:0] btn_q, btn, e;
  logic       ndone, tclr, tdone, lid_ok;
  assign btn = {btn_stop, btn_prog, btn_up, btn_down};
  assign e = btn & ~btn_q;
`ifdef BLENDER_SEQ_LID_INTERLOCK_EN
  assign lid_ok = lid_closed;
  always_ff @(posedge clk)
    lid_fault <= reset ? 1'b0 : ~lid_closed;
`else
  assign lid_ok = 1'b1;
`endif
  blender_tick_timer #(.W(TW)) u_timer (
    .clk(clk),
    .reset(reset),
    .clear(tclr),
    .enable(state == MANUAL || state == PROGRAM),
    .terminal(state == PROGRAM ? TW'(STEP_TICKS) : TW'(IDLE_TIMEOUT)),
    .done(tdone)
  );
  always_comb begin
    ns = state;
    nspeed = speed;
    nstep = step;
    ndone = 1'b0;
    tclr = 1'b0;
    cur = prog_speed(step, MAXS);
    if (!lid_ok || e[3]) ns = IDLE;
    else if (pulse_sel != 2'b00) ns = PULSE;
    else
      case (state)
        IDLE: begin
          ns = e[2] ? PROGRAM : e[1] ? MANUAL : IDLE;
          nspeed = e[1] ? 5'd1 : speed;
          nstep = 2'd0;
        end
        MANUAL: begin
          tclr = e[1] | e[0];
          if (e[2]) ns = PROGRAM;
          else if (e[1]) nspeed = speed >= MAXS ? MAXS : speed + 5'd1;
          else if (e[0]) begin
            nspeed = speed - 5'd1;
            ns = speed == 5'd1 ? IDLE : MANUAL;
          end else if (tdone) ns = IDLE;
        end
        PROGRAM: begin
          if (e[2]) begin
            nstep = 2'd0;
            tclr = 1'b1;
          end else if (e[1] || e[0]) begin
            nspeed = e[1] ? (cur >= MAXS ? MAXS : cur + 5'd1) : cur - 5'd1;
            ns = (!e[1] && cur == 5'd1) ? IDLE : MANUAL;
          end else if (tdone) begin
            ns = step == 2'd3 ? IDLE : PROGRAM;
            ndone = step == 2'd3;
            nstep = step + 2'd1;
            tclr = 1'b1;
          end
        end
        PULSE: ns = IDLE;
      endcase
    tclr = tclr | (ns != state);
    nstep = ns == PROGRAM ? nstep : 2'd0;
    nspeed = ns == IDLE ? 5'd0 : nspeed;
    nmode = ns == MANUAL ? nspeed :
            ns == PROGRAM ? prog_speed(nstep, MAXS) :
            ns == PULSE ? {3'b111, pulse_sel} : MODE_OFF;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      speed <= 5'd0;
      step <= 2'd0;
      btn_q <= 4'd0;
      mode <= MODE_OFF;
      prog_done <= 1'b0;
    end else begin
      state <= ns;
      speed <= nspeed;
      step <= nstep;
      btn_q <= btn;
      mode <= nmode;
      prog_done <= ndone;
    end
  assign prog_active = state == PROGRAM;
  assign step_idx = step;
endmodule
